// File: rtl/rr_slave_arbiter.sv
// rtl/rr_slave_arbiter.sv - per-slave round-robin arbiter with grant hold and registered read return
// Optional watchdog on HOLD enabled by defining ARB_TIMEOUT_EN.
module rr_slave_arbiter #(
    parameter int N      = 32,
    parameter int SLV_ID = 0,
    parameter int TO_CYC = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     m_req,
    input  logic [4*N-1:0] m_addr,
    input  logic [3:0]     m_cmd,
    input  logic [4*N-1:0] m_wdata,
    output logic [3:0]     m_ack,
    output logic [4*N-1:0] m_rdata,
    output logic [3:0]     m_rvalid,
    output logic           s_req,
    output logic [N-1:0]   s_addr,
    output logic           s_cmd,
    output logic [N-1:0]   s_wdata,
    input  logic           s_ack,
    input  logic [N-1:0]   s_rdata,
    output logic [3:0]     grant,
    output logic           busy,
    output logic           timeout
);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic       r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_lock;
    logic [3:0] r_rd_sel;
    logic [3:0] w_elig;
    logic       w_any;
    logic [1:0] w_sel;
    logic [1:0] w_own;
    logic       w_xfer;
    logic       w_to_hit;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_elig[i] = m_req[i] && (m_addr[i*N+N-2 +: 2] == 2'(SLV_ID));
        end
    end

    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        w_sel = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_elig[r_ptr + 2'(k)]) begin
                w_sel = r_ptr + 2'(k);
            end
        end
    end

    assign w_any  = |w_elig;
    assign w_own  = (r_state == ST_HOLD) ? r_lock : w_sel;
    assign busy   = (r_state == ST_HOLD);
    assign s_req  = !reset && ((r_state == ST_HOLD) ? m_req[r_lock] : w_any);
    assign grant  = (!reset && ((r_state == ST_HOLD) || w_any)) ? (4'b0001 << w_own) : 4'b0000;
    assign w_xfer = s_ack && s_req;
    assign m_ack  = grant & {4{w_xfer}};

    always_comb begin
        s_addr  = '0;
        s_cmd   = 1'b0;
        s_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (s_req && (w_own == 2'(i))) begin
                s_addr  = m_addr[i*N +: N];
                s_cmd   = m_cmd[i];
                s_wdata = m_wdata[i*N +: N];
            end
        end
    end

    assign m_rvalid = r_rd_sel;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            m_rdata[i*N +: N] = r_rd_sel[i] ? s_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_lock   <= 2'd0;
            r_rd_sel <= 4'b0000;
        end else begin
            r_rd_sel <= (w_xfer && !s_cmd) ? grant : 4'b0000;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        if (s_ack) begin
                            r_ptr <= w_sel + 2'd1;
                        end else begin
                            r_lock  <= w_sel;
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // A master that withdraws its request forfeits the slot without advancing fairness.
                    if (!m_req[r_lock]) begin
                        r_state <= ST_IDLE;
                    end else if (s_ack || w_to_hit) begin
                        r_ptr   <= r_lock + 2'd1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic [15:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_to_hit  = (r_state == ST_HOLD) && m_req[r_lock] && !s_ack && (w_cnt_nxt == 16'(TO_CYC));
    assign timeout   = r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt <= (r_state == ST_IDLE) ? 16'd0 : w_cnt_nxt;
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYC == 0);
    assign w_to_hit    = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule
